// File: rtl/stream_producer.sv
// AXI-Stream master emitting an 8-bit Galois LFSR byte stream with data-driven idle gaps.
// Ports: clk, rst_n, enable, m_tvalid/m_tdata/m_tlast/m_tready, tx_count, stall_count.
module stream_producer #(
  parameter int          DATA_W    = 8,
  parameter int          PKT_LEN   = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter logic [3:0]  GAP_MASK  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [15:0]       tx_count,
  output logic [15:0]       stall_count
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VALID = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]        state;
  logic [7:0]        lfsr;
  logic [7:0]        lfsr_nxt;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     beat_nxt;
  logic [3:0]        gap_cnt;
  logic [3:0]        gap;
  logic              hs;
  logic [DATA_W-1:0] cur_ext;
  logic [DATA_W-1:0] nxt_ext;

  assign hs       = m_tvalid & m_tready;
  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign beat_nxt = (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
  // The presented beat is always the current lfsr, so its low nibble
  // is the accepted data's low nibble.
  assign gap      = lfsr[3:0] & GAP_MASK;
  assign cur_ext  = DATA_W'(lfsr);
  assign nxt_ext  = DATA_W'(lfsr_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_tlast     <= 1'b0;
      tx_count    <= '0;
      stall_count <= '0;
    end else begin
      if (hs) begin
        tx_count <= tx_count + 16'd1;
        lfsr     <= lfsr_nxt;
        beat_cnt <= beat_nxt;
      end
      if (m_tvalid && !m_tready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_VALID;
            m_tvalid <= 1'b1;
            m_tdata  <= cur_ext;
            m_tlast  <= (beat_cnt == LAST);
          end
        end
        S_VALID: begin
          if (hs) begin
            if (gap == 4'd0 && enable) begin
              m_tdata <= nxt_ext;
              m_tlast <= (beat_nxt == LAST);
            end else begin
              state    <= (gap != 4'd0) ? S_GAP : S_IDLE;
              gap_cnt  <= gap - 4'd1;
              m_tvalid <= 1'b0;
              m_tdata  <= '0;
              m_tlast  <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (enable) begin
            state    <= S_VALID;
            m_tvalid <= 1'b1;
            m_tdata  <= cur_ext;
            m_tlast  <= (beat_cnt == LAST);
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          m_tvalid <= 1'b0;
          m_tdata  <= '0;
          m_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_producer.sv
// Self-checking bench for stream_producer: scoreboarded beats, gap timing,
// stalls, enable drop, async reset, and a back-to-back PKT_LEN=4 instance.
module tb_stream_producer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, tready;
  logic        tvalid, tlast;
  logic [7:0]  tdata;
  logic [15:0] tx, stall;

  logic        rst2_n, en2, rdy2;
  logic        v2, l2;
  logic [7:0]  d2;
  logic [15:0] tx2, st2;

  stream_producer u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .m_tvalid(tvalid), .m_tdata(tdata), .m_tlast(tlast),
    .m_tready(tready), .tx_count(tx), .stall_count(stall)
  );

  stream_producer #(.PKT_LEN(4), .GAP_MASK(4'h0)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .enable(en2),
    .m_tvalid(v2), .m_tdata(d2), .m_tlast(l2),
    .m_tready(rdy2), .tx_count(tx2), .stall_count(st2)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [7:0] m_lfsr;
  int         m_beat;
  logic [8:0] sbq[$];

  function automatic logic [7:0] lfsr_step(logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic model_rst();
    m_lfsr = 8'hA5;
    m_beat = 0;
  endtask

  task automatic push(int n, int plen);
    for (int i = 0; i < n; i++) begin
      sbq.push_back({(m_beat == plen - 1), m_lfsr});
      m_lfsr = lfsr_step(m_lfsr);
      m_beat = (m_beat == plen - 1) ? 0 : m_beat + 1;
    end
  endtask

  bit   gap_en;
  bit   waiting;
  int   idle;
  int   egap;
  logic [8:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      waiting = 0;
      idle    = 0;
    end else begin
      if (waiting) begin
        if (tvalid) begin
          if (gap_en) chk("gap", idle, egap);
          waiting = 0;
        end else begin
          idle++;
        end
      end
      if (tvalid && tready) begin
        chk("sb_nonempty", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("data", tdata, e[7:0]);
          chk("last", tlast, e[8]);
          waiting = 1;
          idle    = 0;
          egap    = int'(e[3:0]);
        end
      end
    end
  end

  task automatic wait_tx(int n, int budget);
    int k;
    k = 0;
    while (tx < 16'(n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (tx < 16'(n)) chk("timeout_tx", tx, n);
  endtask

  task automatic wait_valid(int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!tvalid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!tvalid) chk("timeout_valid", tvalid, 1);
  endtask

  task automatic wait_v2(int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!v2 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!v2) chk("timeout_v2", v2, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    model_rst();
    sbq.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    logic [7:0] ml;
    rst_n  = 1'b0;
    enable = 1'b1;
    tready = 1'b1;
    gap_en = 1'b1;
    rst2_n = 1'b0;
    en2    = 1'b1;
    rdy2   = 1'b1;
    #1;
    chk("rst_valid", tvalid, 0);
    chk("rst_data",  tdata,  0);
    chk("rst_last",  tlast,  0);
    chk("rst_tx",    tx,     0);
    chk("rst_stall", stall,  0);

    // free-running, tready constant high
    model_rst();
    push(8, 16);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_tx(4, 200);
    chk("t1_tx", tx, 4);
    chk("t1_stall", stall, 0);
    chk("t1_sb_left", sbq.size(), 4);

    // stall on the first beat, then drop enable during a second stall
    tready = 1'b0;
    do_reset();
    push(2, 16);
    wait_valid(20);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_v", tvalid, 1);
      chk("stall_d", tdata, 8'hA5);
    end
    @(posedge clk);
    #1 tready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_tx", tx, 1);
    chk("t2_stall", stall, 3);
    tready = 1'b0;
    wait_valid(30);
    #1 enable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("hold_v", tvalid, 1);
      chk("hold_d", tdata, 8'hEA);
    end
    @(posedge clk);
    #1 tready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_tx", tx, 2);
    chk("t4_stall", stall, 6);
    nv = 0;
    repeat (25) begin
      @(negedge clk);
      if (tvalid) nv++;
    end
    chk("t4_no_valid", nv, 0);
    gap_en = 1'b0;
    push(1, 16);
    enable = 1'b1;
    wait_tx(3, 50);
    enable = 1'b0;
    chk("t4_sb_left", sbq.size(), 0);

    // async reset between edges while in a gap
    enable = 1'b1;
    gap_en = 1'b1;
    do_reset();
    push(2, 16);
    wait_tx(2, 100);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", tvalid, 0);
    chk("ar_data",  tdata,  0);
    chk("ar_tx",    tx,     0);
    chk("ar_stall", stall,  0);
    @(negedge clk);
    model_rst();
    sbq.delete();
    push(1, 16);
    #1 rst_n = 1'b1;
    wait_tx(1, 50);
    enable = 1'b0;
    chk("ar_sb_left", sbq.size(), 0);

    // back-to-back packets of 4
    @(negedge clk);
    #1 rst2_n = 1'b1;
    wait_v2(10);
    ml = 8'hA5;
    for (int i = 0; i < 14; i++) begin
      chk("b2b_v", v2, 1);
      chk("b2b_d", d2, ml);
      chk("b2b_l", l2, (i % 4 == 3));
      ml = lfsr_step(ml);
      @(negedge clk);
    end
    #2 rst2_n = 1'b0;
    #1;
    chk("b2b_rst_v", v2, 0);
    chk("b2b_rst_tx", tx2, 0);
    @(negedge clk);
    #1 rst2_n = 1'b1;
    wait_v2(10);
    ml = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      chk("re_d", d2, ml);
      chk("re_l", l2, (i == 3));
      ml = lfsr_step(ml);
      @(negedge clk);
    end
    chk("b2b_stall", st2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
